subroutine_stack: RTL and testbench

Hardware call/return stack serving the control unit's push_stack / pop_stack micro-ops.
- CALL: control unit pushes the return PC together with the current 4-bit flags.
- RETURN: a pop restores both; the flags feed the control unit's stack-flags input.
- Block owns stack pointer, storage array, full/empty tracking, error reporting and the pop read sequencing (synchronous RAM, one-cycle read).

---
 rtl/subroutine_stack.sv | 151 +++++++++++++++
 tb/tb_subroutine_stack.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/subroutine_stack.sv
// Hardware call/return stack: pushes {return PC, flags}, pops them back via a one-cycle synchronous read.
// Optional macro SUBROUTINE_STACK_WRAP_EN: a push while full overwrites the oldest entry instead of dropping.
module subroutine_stack #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 8,
    parameter int FLAG_W = 4,
    parameter int PTR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_push_en,
    input  logic              in_pop_en,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic              in_clear_err,
    output logic [PC_W-1:0]   out_pc,
    output logic [FLAG_W-1:0] out_flags,
    output logic              out_valid,
    output logic              out_busy,
    output logic              out_full,
    output logic              out_empty,
    output logic [PTR_W:0]    out_depth,
    output logic              out_overflow,
    output logic              out_underflow
);

    if (PTR_W != $clog2(DEPTH)) begin : g_bad_ptr_w
        $error("subroutine_stack: PTR_W must equal $clog2(DEPTH)");
    end

    localparam logic [PTR_W:0] L_DEPTH_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [PTR_W-1:0]         r_sp;
    logic [PTR_W-1:0]         r_addr;
    logic [PTR_W:0]           r_depth;
    logic [PC_W-1:0]          r_out_pc;
    logic [FLAG_W-1:0]        r_out_flags;
    logic                     r_valid;
    logic                     r_ovf;
    logic                     r_unf;
    logic [PC_W+FLAG_W-1:0]   r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_full  = (r_depth == L_DEPTH_FULL);
    assign w_empty = (r_depth == '0);

    // Push has priority over pop; any request seen while READ is in flight is dropped silently.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_push_en) begin
                    if (!w_full) begin
                        w_push = 1'b1;
                    end else begin
                        w_ovf_set = 1'b1;
`ifdef SUBROUTINE_STACK_WRAP_EN
                        w_push    = 1'b1;
`endif
                    end
                end else if (in_pop_en) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_READ;
                    end else begin
                        w_unf_set = 1'b1;
                    end
                end
            end
            ST_READ: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_sp] <= {in_pc, in_flags};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sp        <= '0;
            r_addr      <= '0;
            r_depth     <= '0;
            r_out_pc    <= '0;
            r_out_flags <= '0;
            r_valid     <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= 1'b0;
            if (w_push) begin
                r_sp <= r_sp + PTR_W'(1);
                // A wrapping push when full keeps depth pinned at DEPTH.
                if (!w_full) begin
                    r_depth <= r_depth + (PTR_W+1)'(1);
                end
            end
            if (w_pop) begin
                r_sp    <= r_sp - PTR_W'(1);
                r_addr  <= r_sp - PTR_W'(1);
                r_depth <= r_depth - (PTR_W+1)'(1);
            end
            if (r_state == ST_READ) begin
                {r_out_pc, r_out_flags} <= r_mem[r_addr];
                r_valid                 <= 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (in_clear_err) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (in_clear_err) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign out_pc        = r_out_pc;
    assign out_flags     = r_out_flags;
    assign out_valid     = r_valid;
    assign out_busy      = (r_state == ST_READ);
    assign out_full      = w_full;
    assign out_empty     = w_empty;
    assign out_depth     = r_depth;
    assign out_overflow  = r_ovf;
    assign out_underflow = r_unf;

endmodule

// File: tb/tb_subroutine_stack.sv
// Scoreboard bench for subroutine_stack: pops queue expected {pc,flags}, a monitor checks each out_valid pulse.
module tb_subroutine_stack;

    logic       clk;
    logic       rst;
    logic       in_push_en;
    logic       in_pop_en;
    logic [7:0] in_pc;
    logic [3:0] in_flags;
    logic       in_clear_err;
    logic [7:0] out_pc;
    logic [3:0] out_flags;
    logic       out_valid;
    logic       out_busy;
    logic       out_full;
    logic       out_empty;
    logic [4:0] out_depth;
    logic       out_overflow;
    logic       out_underflow;

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_q [$];

    subroutine_stack #(
        .DEPTH  (16),
        .PC_W   (8),
        .FLAG_W (4),
        .PTR_W  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_push_en    (in_push_en),
        .in_pop_en     (in_pop_en),
        .in_pc         (in_pc),
        .in_flags      (in_flags),
        .in_clear_err  (in_clear_err),
        .out_pc        (out_pc),
        .out_flags     (out_flags),
        .out_valid     (out_valid),
        .out_busy      (out_busy),
        .out_full      (out_full),
        .out_empty     (out_empty),
        .out_depth     (out_depth),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_data: unexpected out_valid got pc=%h flags=%h", out_pc, out_flags);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({out_pc, out_flags} !== e) begin
                    failures++;
                    $display("FAIL pop_data: got pc=%h flags=%h expected pc=%h flags=%h",
                             out_pc, out_flags, e[11:4], e[3:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_push(input logic [7:0] pc, input logic [3:0] fl);
        in_push_en = 1'b1;
        in_pc      = pc;
        in_flags   = fl;
        tick();
        in_push_en = 1'b0;
    endtask

    task automatic do_pop(input logic [7:0] pc, input logic [3:0] fl);
        exp_q.push_back({pc, fl});
        in_pop_en = 1'b1;
        tick();
        in_pop_en = 1'b0;
        check("busy_in_read", int'(out_busy), 1);
        tick();
        tick();
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            do_push(8'(i), 4'(i));
        end
    endtask

    // k-th pop (k=0 first) after 16 pushes of 0..15 plus one extra push of AA/A while full.
    function automatic logic [11:0] after_fill(input int k);
`ifdef SUBROUTINE_STACK_WRAP_EN
        if (k == 0) return 12'hAAA;
        return {8'(16 - k), 4'(16 - k)};
`else
        return {8'(15 - k), 4'(15 - k)};
`endif
    endfunction

    initial begin
        logic [11:0] e;
        rst = 1'b1; in_push_en = 1'b0; in_pop_en = 1'b0;
        in_pc = '0; in_flags = '0; in_clear_err = 1'b0;
        do_reset();

        check("rst_depth", int'(out_depth), 0);
        check("rst_empty", int'(out_empty), 1);
        check("rst_full", int'(out_full), 0);
        check("rst_pc", int'(out_pc), 0);
        check("rst_flags", int'(out_flags), 0);
        check("rst_busy", int'(out_busy), 0);
        check("rst_ovf", int'(out_overflow), 0);
        check("rst_unf", int'(out_underflow), 0);

        // Basic LIFO
        do_push(8'h12, 4'h3);
        do_push(8'h34, 4'h5);
        check("depth_two", int'(out_depth), 2);
        do_pop(8'h34, 4'h5);
        do_pop(8'h12, 4'h3);
        check("empty_after_pops", int'(out_empty), 1);
        check("depth_zero", int'(out_depth), 0);
        check("hold_pc", int'(out_pc), 8'h12);

        // Underflow after reset
        do_reset();
        in_pop_en = 1'b1;
        tick();
        in_pop_en = 1'b0;
        check("unf_set", int'(out_underflow), 1);
        check("unf_not_busy", int'(out_busy), 0);
        tick();
        check("unf_pc_zero", int'(out_pc), 0);
        in_clear_err = 1'b1;
        tick();
        in_clear_err = 1'b0;
        check("unf_cleared", int'(out_underflow), 0);

        // Fill, overflow, drain
        fill16();
        check("full_flag", int'(out_full), 1);
        check("full_depth", int'(out_depth), 16);
        check("full_ovf_clear", int'(out_overflow), 0);
        do_push(8'hAA, 4'hA);
        check("ovf_set", int'(out_overflow), 1);
        check("ovf_depth", int'(out_depth), 16);
        for (int k = 0; k < 16; k++) begin
            e = after_fill(k);
            do_pop(e[11:4], e[3:0]);
        end
        check("drained_empty", int'(out_empty), 1);

        // Simultaneous push/pop, pop during busy
        do_reset();
        do_push(8'h55, 4'h1);
        in_push_en = 1'b1; in_pop_en = 1'b1; in_pc = 8'h66; in_flags = 4'h2;
        tick();
        in_push_en = 1'b0;
        check("pushpop_depth", int'(out_depth), 2);
        exp_q.push_back({8'h66, 4'h2});
        tick();
        check("pop_hold_busy", int'(out_busy), 1);
        tick();
        in_pop_en = 1'b0;
        check("busy_pop_ignored_depth", int'(out_depth), 1);
        tick();
        check("busy_pop_depth_after", int'(out_depth), 1);
        check("busy_no_unf", int'(out_underflow), 0);
        do_pop(8'h55, 4'h1);

        // Reset during READ
        do_reset();
        in_pop_en = 1'b1;
        tick();
        in_pop_en = 1'b0;
        check("pre_rst_unf", int'(out_underflow), 1);
        do_push(8'h77, 4'h7);
        in_pop_en = 1'b1;
        tick();
        in_pop_en = 1'b0;
        check("pre_rst_busy", int'(out_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstread_valid", int'(out_valid), 0);
        check("rstread_depth", int'(out_depth), 0);
        check("rstread_pc", int'(out_pc), 0);
        check("rstread_ovf", int'(out_overflow), 0);
        check("rstread_unf", int'(out_underflow), 0);
        tick();
        check("rstread_valid_late", int'(out_valid), 0);

        // Error set wins over clear; clear while pushing
        fill16();
        in_clear_err = 1'b1;
        do_push(8'hAA, 4'hA);
        in_clear_err = 1'b0;
        check("set_wins_ovf", int'(out_overflow), 1);
        for (int k = 0; k < 13; k++) begin
            e = after_fill(k);
            do_pop(e[11:4], e[3:0]);
        end
        check("depth_three", int'(out_depth), 3);
        check("ovf_still_set", int'(out_overflow), 1);
        in_clear_err = 1'b1;
        do_push(8'hC0, 4'hC);
        in_clear_err = 1'b0;
        check("clear_on_push_ovf", int'(out_overflow), 0);
        check("clear_on_push_depth", int'(out_depth), 4);
        do_pop(8'hC0, 4'hC);
        check("depth_back_three", int'(out_depth), 3);

        tick();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
